// File: rtl/difftest_trap_pkg.sv
// rtl/difftest_trap_pkg.sv - shared event type and defaults for the difftest trap arbiter
package difftest_trap_pkg;

  localparam logic [2:0] DEFAULT_TIMEOUT_CODE = 3'd6;

  typedef struct packed {
    logic        hasTrap;
    logic        hasWFI;
    logic [2:0]  code;
    logic [63:0] pc;
    logic [63:0] cycleCnt;
    logic [63:0] instrCnt;
  } trap_evt_t;

  // Synthetic trap reported when a core stops making progress.
  function automatic trap_evt_t timeout_evt(input logic [2:0] code);
    trap_evt_t e;
    e          = '0;
    e.hasTrap  = 1'b1;
    e.code     = code;
    return e;
  endfunction

endpackage

// File: rtl/trap_event_slot.sv
// rtl/trap_event_slot.sv - one-entry per-core event buffer with halt flag and watchdog
module trap_event_slot
  import difftest_trap_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 0,
  parameter logic [2:0] TIMEOUT_CODE   = DEFAULT_TIMEOUT_CODE
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      valid,
  input  trap_evt_t evt_in,
  output logic      ready,
  output logic      full,
  output trap_evt_t evt,
  input  logic      grant,
  input  logic      grant_with_trap,
  output logic      halted,
  output logic      drop
);

  localparam bit WDOG_EN  = (TIMEOUT_CYCLES > 0);
  localparam int IDLE_MAX = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam int IDLE_W   = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;

  logic [IDLE_W-1:0] idle;
  logic              accept;
  logic              at_limit;
  logic              inject;

  // Halted cores keep ready high so their stray events are swallowed.
  assign ready    = !full || halted;
  assign accept   = valid && !full && !halted;
  assign drop     = valid && full && !halted;
  assign at_limit = WDOG_EN && (idle == IDLE_W'(IDLE_MAX));
  assign inject   = at_limit && !full && !halted && !accept;

  always_ff @(posedge clock) begin
    if (reset) begin
      full   <= 1'b0;
      evt    <= '0;
      halted <= 1'b0;
      idle   <= '0;
    end else begin
      if (accept) begin
        full <= 1'b1;
        evt  <= evt_in;
      end else if (inject) begin
        full <= 1'b1;
        evt  <= timeout_evt(TIMEOUT_CODE);
      end else if (grant) begin
        full <= 1'b0;
      end

      halted <= halted || grant_with_trap;

      // At the limit with a full slot the counter parks until the slot drains.
      if (!WDOG_EN || accept || inject) begin
        idle <= '0;
      end else if (!halted && !at_limit) begin
        idle <= idle + IDLE_W'(1);
      end
    end
  end

endmodule

// File: rtl/difftest_trap_arbiter.sv
// rtl/difftest_trap_arbiter.sv - round-robin merge of per-core trap events onto one report port
module difftest_trap_arbiter
  import difftest_trap_pkg::*;
#(
  parameter int         NUM_CORES      = 2,
  parameter int         TIMEOUT_CYCLES = 0,
  parameter logic [2:0] TIMEOUT_CODE   = DEFAULT_TIMEOUT_CODE,
  parameter int         DROP_CNT_W     = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    in_valid,
  output logic [NUM_CORES-1:0]    in_ready,
  input  logic [NUM_CORES-1:0]    in_hasTrap,
  input  logic [NUM_CORES-1:0]    in_hasWFI,
  input  logic [3*NUM_CORES-1:0]  in_code,
  input  logic [64*NUM_CORES-1:0] in_pc,
  input  logic [64*NUM_CORES-1:0] in_cycleCnt,
  input  logic [64*NUM_CORES-1:0] in_instrCnt,
  output logic                    out_enable,
  output logic                    out_hasTrap,
  output logic                    out_hasWFI,
  output logic [2:0]              out_code,
  output logic [63:0]             out_pc,
  output logic [63:0]             out_cycleCnt,
  output logic [63:0]             out_instrCnt,
  output logic [7:0]              out_coreid,
  output logic [NUM_CORES-1:0]    core_halted,
  output logic                    all_halted,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int               PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W:0]   NC_EXT   = (PTR_W + 1)'(NUM_CORES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CORES - 1);

  logic [NUM_CORES-1:0]  slot_full;
  logic [NUM_CORES-1:0]  grant_vec;
  logic [NUM_CORES-1:0]  drop_vec;
  trap_evt_t             slot_evt [NUM_CORES];
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [3:0]            drop_num;
  logic [DROP_CNT_W+3:0] drop_sum;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    trap_evt_t evt_in;

    assign evt_in = {in_hasTrap[i], in_hasWFI[i], in_code[3*i +: 3], in_pc[64*i +: 64],
                     in_cycleCnt[64*i +: 64], in_instrCnt[64*i +: 64]};
    assign grant_vec[i] = grant_any && (grant_idx == PTR_W'(i));

    trap_event_slot #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_CODE   (TIMEOUT_CODE)
    ) u_slot (
      .clock           (clock),
      .reset           (reset),
      .valid           (in_valid[i]),
      .evt_in          (evt_in),
      .ready           (in_ready[i]),
      .full            (slot_full[i]),
      .evt             (slot_evt[i]),
      .grant           (grant_vec[i]),
      .grant_with_trap (grant_vec[i] && slot_evt[i].hasTrap),
      .halted          (core_halted[i]),
      .drop            (drop_vec[i])
    );
  end

  assign all_halted = &core_halted;

  // First full slot at or after rr_ptr, wrapping at NUM_CORES.
  always_comb begin
    logic [PTR_W:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= NC_EXT) begin
        cand = cand - NC_EXT;
      end
      if (!grant_any && slot_full[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_num = drop_num + 4'(drop_vec[i]);
    end
  end

  assign drop_sum = {4'b0000, drop_cnt} + {{DROP_CNT_W{1'b0}}, drop_num};

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr       <= '0;
      out_enable   <= 1'b0;
      out_hasTrap  <= 1'b0;
      out_hasWFI   <= 1'b0;
      out_code     <= '0;
      out_pc       <= '0;
      out_cycleCnt <= '0;
      out_instrCnt <= '0;
      out_coreid   <= '0;
      drop_cnt     <= '0;
    end else begin
      out_enable <= grant_any;
      if (grant_any) begin
        rr_ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
        out_hasTrap  <= slot_evt[grant_idx].hasTrap;
        out_hasWFI   <= slot_evt[grant_idx].hasWFI;
        out_code     <= slot_evt[grant_idx].code;
        out_pc       <= slot_evt[grant_idx].pc;
        out_cycleCnt <= slot_evt[grant_idx].cycleCnt;
        out_instrCnt <= slot_evt[grant_idx].instrCnt;
        out_coreid   <= 8'(grant_idx);
      end
      // Overflow into the top four bits means the counter has saturated.
      if (drop_sum[DROP_CNT_W+3:DROP_CNT_W] != 4'b0000) begin
        drop_cnt <= '1;
      end else begin
        drop_cnt <= drop_sum[DROP_CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_difftest_trap_arbiter.sv
// tb/tb_difftest_trap_arbiter.sv - self-checking bench for difftest_trap_arbiter
module tb_difftest_trap_arbiter;

  localparam int NC   = 2;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  typedef struct packed {
    logic        trap;
    logic        wfi;
    logic [2:0]  code;
    logic [63:0] pc;
    logic [63:0] cc;
    logic [63:0] ic;
  } ev_t;

  logic clock;
  logic reset;

  logic [NC-1:0]    in_valid, in_ready, in_hasTrap, in_hasWFI;
  logic [3*NC-1:0]  in_code;
  logic [64*NC-1:0] in_pc, in_cycleCnt, in_instrCnt;
  logic             out_enable, out_hasTrap, out_hasWFI, all_halted;
  logic [2:0]       out_code;
  logic [63:0]      out_pc, out_cycleCnt, out_instrCnt;
  logic [7:0]       out_coreid;
  logic [NC-1:0]    core_halted;
  logic [DW-1:0]    drop_cnt;

  logic [NC-1:0]    wd_valid, wd_ready, wd_hasTrap, wd_hasWFI;
  logic [3*NC-1:0]  wd_code;
  logic [64*NC-1:0] wd_pc, wd_cycleCnt, wd_instrCnt;
  logic             wd_enable, wd_out_hasTrap, wd_out_hasWFI, wd_all_halted;
  logic [2:0]       wd_out_code;
  logic [63:0]      wd_out_pc, wd_out_cycleCnt, wd_out_instrCnt;
  logic [7:0]       wd_coreid;
  logic [NC-1:0]    wd_halted;
  logic [15:0]      wd_drop_cnt;

  difftest_trap_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(0), .DROP_CNT_W(DW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_hasTrap(in_hasTrap), .in_hasWFI(in_hasWFI),
    .in_code(in_code), .in_pc(in_pc), .in_cycleCnt(in_cycleCnt), .in_instrCnt(in_instrCnt),
    .out_enable(out_enable), .out_hasTrap(out_hasTrap), .out_hasWFI(out_hasWFI),
    .out_code(out_code), .out_pc(out_pc), .out_cycleCnt(out_cycleCnt),
    .out_instrCnt(out_instrCnt), .out_coreid(out_coreid), .core_halted(core_halted),
    .all_halted(all_halted), .drop_cnt(drop_cnt)
  );

  difftest_trap_arbiter #(.NUM_CORES(NC), .TIMEOUT_CYCLES(8), .DROP_CNT_W(16)) wd (
    .clock(clock), .reset(reset),
    .in_valid(wd_valid), .in_ready(wd_ready), .in_hasTrap(wd_hasTrap), .in_hasWFI(wd_hasWFI),
    .in_code(wd_code), .in_pc(wd_pc), .in_cycleCnt(wd_cycleCnt), .in_instrCnt(wd_instrCnt),
    .out_enable(wd_enable), .out_hasTrap(wd_out_hasTrap), .out_hasWFI(wd_out_hasWFI),
    .out_code(wd_out_code), .out_pc(wd_out_pc), .out_cycleCnt(wd_out_cycleCnt),
    .out_instrCnt(wd_out_instrCnt), .out_coreid(wd_coreid), .core_halted(wd_halted),
    .all_halted(wd_all_halted), .drop_cnt(wd_drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_bad;

  // Reference model: pending event per core, halt flags, round-robin pointer, report register.
  bit   m_full [NC];
  bit   m_halt [NC];
  ev_t  m_slot [NC];
  int   m_rr, m_drop, m_outid;
  bit   m_en;
  ev_t  m_out;

  function automatic ev_t mk_ev(input bit trap, input bit [2:0] code, input bit [63:0] pc);
    ev_t e;
    e.trap = trap; e.wfi = 1'b0; e.code = code; e.pc = pc;
    e.cc = pc + 64'd100; e.ic = pc + 64'd7;
    return e;
  endfunction

  function automatic ev_t cur_in(input int i);
    ev_t e;
    e.trap = in_hasTrap[i]; e.wfi = in_hasWFI[i]; e.code = in_code[3*i +: 3];
    e.pc = in_pc[64*i +: 64]; e.cc = in_cycleCnt[64*i +: 64]; e.ic = in_instrCnt[64*i +: 64];
    return e;
  endfunction

  function automatic logic [NC-1:0] m_ready();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = m_halt[i] || !m_full[i];
    return r;
  endfunction

  function automatic logic [NC-1:0] m_halt_vec();
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = m_halt[i];
    return r;
  endfunction

  task automatic set_core(input int i, input bit v, input ev_t e);
    in_valid[i] = v; in_hasTrap[i] = e.trap; in_hasWFI[i] = e.wfi; in_code[3*i +: 3] = e.code;
    in_pc[64*i +: 64] = e.pc; in_cycleCnt[64*i +: 64] = e.cc; in_instrCnt[64*i +: 64] = e.ic;
  endtask

  task automatic clear_inputs();
    in_valid = '0; in_hasTrap = '0; in_hasWFI = '0; in_code = '0;
    in_pc = '0; in_cycleCnt = '0; in_instrCnt = '0;
  endtask

  task automatic clear_wd();
    wd_valid = '0; wd_hasTrap = '0; wd_hasWFI = '0; wd_code = '0;
    wd_pc = '0; wd_cycleCnt = '0; wd_instrCnt = '0;
  endtask

  // Advance the model over one rising edge from the inputs now applied, then clock the DUT.
  task automatic tick();
    bit  nf [NC];
    bit  nh [NC];
    ev_t ns [NC];
    int  g, drops, idx;
    if (reset) begin
      for (int i = 0; i < NC; i++) begin m_full[i] = 0; m_halt[i] = 0; m_slot[i] = '0; end
      m_rr = 0; m_drop = 0; m_outid = 0; m_en = 0; m_out = '0;
    end else begin
      nf = m_full; nh = m_halt; ns = m_slot;
      g = -1;
      for (int k = 0; k < NC; k++) begin
        idx = (m_rr + k) % NC;
        if (g < 0 && m_full[idx]) g = idx;
      end
      m_en = (g >= 0);
      if (g >= 0) begin
        m_out = m_slot[g]; m_outid = g; m_rr = (g + 1) % NC; nf[g] = 0;
        if (m_slot[g].trap) nh[g] = 1;
      end
      drops = 0;
      for (int i = 0; i < NC; i++) begin
        if (in_valid[i] && !m_halt[i]) begin
          if (m_full[i]) drops++;
          else begin nf[i] = 1; ns[i] = cur_in(i); end
        end
      end
      m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
      m_full = nf; m_halt = nh; m_slot = ns;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear_inputs(); tick(); tick(); reset = 1'b0;
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b want 0", out_enable); end
    n_cmp++; if (out_pc !== 64'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_cmp++; if (out_coreid !== 8'd0) begin n_bad++; $display("FAIL reset_coreid: got %0d want 0", out_coreid); end
    n_cmp++; if (core_halted !== 2'b00 || all_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b/%b want 00/0", core_halted, all_halted); end
    n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL reset_ready: got %b want 11", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    set_core(0, 1'b1, mk_ev(1'b0, 3'd0, 64'h8000_0000));
    tick(); clear_inputs();
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL single_t1_enable: got %b want 0", out_enable); end
    tick();
    n_cmp++; if (out_enable !== 1'b1) begin n_bad++; $display("FAIL single_t2_enable: got %b want 1", out_enable); end
    n_cmp++; if (out_pc !== 64'h8000_0000) begin n_bad++; $display("FAIL single_pc: got %h want 80000000", out_pc); end
    n_cmp++; if (out_coreid !== 8'd0 || core_halted !== 2'b00) begin n_bad++; $display("FAIL single_id_halt: got %0d/%b want 0/00", out_coreid, core_halted); end
    tick();
    n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL single_t3_enable: got %b want 0", out_enable); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NC; i++) set_core(i, 1'b1, mk_ev(1'b0, 3'(i + 1), 64'h100 + 64'(16 * r + i)));
      tick(); clear_inputs(); tick();
      for (int i = 0; i < NC; i++) begin
        n_cmp++;
        if (out_enable !== 1'b1 || out_coreid !== 8'(i) || out_pc !== 64'h100 + 64'(16 * r + i)) begin
          n_bad++;
          $display("FAIL contention_r%0d_c%0d: got en=%b id=%0d pc=%h want en=1 id=%0d pc=%h",
                   r, i, out_enable, out_coreid, out_pc, i, 64'h100 + 64'(16 * r + i));
        end
        if (i < NC - 1) tick();
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_en;
    exp_en = 4'b1010;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        n_cmp++;
        if (in_ready[1] !== (c != 1)) begin n_bad++; $display("FAIL b2b_ready_%0d: got %b want %b", c, in_ready[1], c != 1); end
        set_core(1, 1'b1, mk_ev(1'b0, 3'd2, 64'hA00 + 64'(c)));
      end else begin
        clear_inputs();
      end
      tick();
      n_cmp++;
      if (out_enable !== exp_en[c]) begin n_bad++; $display("FAIL b2b_enable_%0d: got %b want %b", c, out_enable, exp_en[c]); end
      if (exp_en[c]) begin
        n_cmp++;
        if (out_pc !== ((c == 1) ? 64'hA00 : 64'hA02) || out_coreid !== 8'd1) begin
          n_bad++; $display("FAIL b2b_report_%0d: got pc=%h id=%0d", c, out_pc, out_coreid);
        end
      end
    end
    n_cmp++; if (drop_cnt !== 4'd1) begin n_bad++; $display("FAIL b2b_drop: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    set_core(0, 1'b1, mk_ev(1'b1, 3'd0, 64'hDEAD));
    tick(); clear_inputs(); tick();
    n_cmp++; if (out_enable !== 1'b1 || out_hasTrap !== 1'b1) begin n_bad++; $display("FAIL halt_report: got en=%b trap=%b want 1/1", out_enable, out_hasTrap); end
    n_cmp++; if (core_halted !== 2'b01 || all_halted !== 1'b0) begin n_bad++; $display("FAIL halt_core0: got %b/%b want 01/0", core_halted, all_halted); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (in_ready[0] !== 1'b1) begin n_bad++; $display("FAIL halt_ready_%0d: got %b want 1", c, in_ready[0]); end
      set_core(0, 1'b1, mk_ev(1'b0, 3'd1, 64'hBEEF));
      tick();
      n_cmp++; if (out_enable !== 1'b0 || drop_cnt !== 4'd0) begin n_bad++; $display("FAIL halt_swallow_%0d: got en=%b drop=%0d want 0/0", c, out_enable, drop_cnt); end
    end
    clear_inputs();
    set_core(1, 1'b1, mk_ev(1'b1, 3'd3, 64'hC0DE));
    tick(); clear_inputs(); tick();
    n_cmp++; if (out_coreid !== 8'd1 || core_halted !== 2'b11 || all_halted !== 1'b1) begin
      n_bad++; $display("FAIL halt_all: got id=%0d halted=%b all=%b want 1/11/1", out_coreid, core_halted, all_halted);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_core(0, 1'b1, mk_ev(1'b1, 3'd0, 64'h10));
    tick();
    set_core(0, 1'b1, mk_ev(1'b0, 3'd0, 64'h20));
    set_core(1, 1'b1, mk_ev(1'b0, 3'd0, 64'h30));
    tick();
    n_cmp++; if (core_halted !== 2'b01 || drop_cnt !== 4'd1) begin n_bad++; $display("FAIL midrst_pre: got halted=%b drop=%0d want 01/1", core_halted, drop_cnt); end
    reset = 1'b1; tick(); reset = 1'b0; clear_inputs();
    n_cmp++; if (in_ready !== 2'b11 || drop_cnt !== 4'd0 || core_halted !== 2'b00) begin
      n_bad++; $display("FAIL midrst_state: got ready=%b drop=%0d halted=%b want 11/0/00", in_ready, drop_cnt, core_halted);
    end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (out_enable !== 1'b0) begin n_bad++; $display("FAIL midrst_enable_%0d: got %b want 0", c, out_enable); end
      tick();
    end
  endtask

  task automatic test_watchdog();
    bit exp_en;
    clear_wd(); clear_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      clear_wd();
      if (n == 3) begin wd_valid[0] = 1'b1; wd_pc[63:0] = 64'h1234; end
      tick();
      exp_en = (n == 4 || n == 9 || n == 12);
      n_cmp++; if (wd_enable !== exp_en) begin n_bad++; $display("FAIL wdog_enable_%0d: got %b want %b", n, wd_enable, exp_en); end
      if (n == 4) begin
        n_cmp++; if (wd_coreid !== 8'd0 || wd_out_pc !== 64'h1234 || wd_out_hasTrap !== 1'b0) begin
          n_bad++; $display("FAIL wdog_real: got id=%0d pc=%h trap=%b want 0/1234/0", wd_coreid, wd_out_pc, wd_out_hasTrap);
        end
      end
      if (n == 9 || n == 12) begin
        n_cmp++;
        if (wd_coreid !== ((n == 9) ? 8'd1 : 8'd0) || wd_out_code !== 3'd6 || wd_out_pc !== 64'd0 || wd_out_hasTrap !== 1'b1) begin
          n_bad++; $display("FAIL wdog_inject_%0d: got id=%0d code=%0d pc=%h trap=%b", n, wd_coreid, wd_out_code, wd_out_pc, wd_out_hasTrap);
        end
        n_cmp++;
        if (wd_halted !== ((n == 9) ? 2'b10 : 2'b11)) begin n_bad++; $display("FAIL wdog_halted_%0d: got %b", n, wd_halted); end
      end
    end
    n_cmp++; if (wd_all_halted !== 1'b1) begin n_bad++; $display("FAIL wdog_all_halted: got %b want 1", wd_all_halted); end
  endtask

  task automatic test_random();
    ev_t e;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset = (cyc % 150 == 149);
      for (int i = 0; i < NC; i++) begin
        e.trap = ($urandom_range(0, 15) == 0);
        e.wfi  = $urandom_range(0, 1);
        e.code = 3'($urandom_range(0, 7));
        e.pc   = {$urandom, $urandom};
        e.cc   = {$urandom, $urandom};
        e.ic   = {$urandom, $urandom};
        set_core(i, ($urandom_range(0, 9) < 6), e);
      end
      tick();
      n_cmp++; if (out_enable !== m_en) begin n_bad++; $display("FAIL rand_enable@%0d: got %b want %b", cyc, out_enable, m_en); end
      n_cmp++;
      if ({out_hasTrap, out_hasWFI, out_code, out_pc, out_cycleCnt, out_instrCnt, out_coreid} !== {m_out, 8'(m_outid)}) begin
        n_bad++; $display("FAIL rand_report@%0d: got id=%0d pc=%h code=%0d want id=%0d pc=%h code=%0d",
                          cyc, out_coreid, out_pc, out_code, m_outid, m_out.pc, m_out.code);
      end
      n_cmp++; if (core_halted !== m_halt_vec() || all_halted !== (&m_halt_vec())) begin n_bad++; $display("FAIL rand_halted@%0d: got %b want %b", cyc, core_halted, m_halt_vec()); end
      n_cmp++; if (in_ready !== m_ready()) begin n_bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, in_ready, m_ready()); end
      n_cmp++; if (drop_cnt !== DW'(m_drop)) begin n_bad++; $display("FAIL rand_drop@%0d: got %0d want %0d", cyc, drop_cnt, m_drop); end
    end
    reset = 1'b0; clear_inputs();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1;
    clear_inputs(); clear_wd();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_halt();
    test_mid_reset();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
